// File: rtl/one_wire_temp_sequencer.sv
// DS18B20-style temperature cycle sequencer driving a one_wire_commands block.
// Define ONE_WIRE_CRC_EN to read the full 9-byte scratchpad and verify its Dallas CRC-8.
module one_wire_temp_sequencer #(
    parameter int SYSCLOCK  = 24576000,
    parameter int CONV_MS   = 750,
    parameter int DLY_WIDTH = 25
) (
    input  logic        s_clock,
    input  logic        s_reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] temperature,
    output logic        temp_valid,
    output logic        no_device,
    output logic        crc_error,
    output logic [7:0]  cmd_datain,
    output logic        cmd_write,
    output logic        cmd_read,
    output logic        cmd_chipselect,
    output logic        cmd_bus_reset,
    input  logic        cmd_busy,
    input  logic        cmd_no_device,
    input  logic [7:0]  cmd_rxdata
);

`ifdef ONE_WIRE_CRC_EN
    localparam int NBYTES = 9;
`else
    localparam int NBYTES = 2;
`endif
    localparam logic [DLY_WIDTH-1:0] DLY_LAST = DLY_WIDTH'((SYSCLOCK / 1000) * CONV_MS - 1);
    localparam logic [3:0]           LAST_IDX = 4'(NBYTES - 1);

    typedef enum logic [4:0] {
        S_IDLE, S_RST1, S_RST1_W, S_SKIP1, S_SKIP1_W, S_CONV, S_CONV_W, S_DELAY,
        S_RST2, S_RST2_W, S_SKIP2, S_SKIP2_W, S_RDCMD, S_RDCMD_W, S_RDB, S_RDB_W,
        S_CRC, S_TERM, S_TERM_W, S_CHECK, S_DONE, S_FAIL
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_pending;
    logic [DLY_WIDTH-1:0]   r_dly;
    logic [3:0]             r_index;
    logic [7:0]             r_byte0;
    logic [7:0]             r_byte1;
    logic [15:0]            r_temperature;
    logic                   r_temp_valid;
    logic                   r_no_device;
    logic                   w_fail_crc;
    logic                   w_rd_done;

    assign w_rd_done = (r_state == S_RDB_W) && !cmd_busy;

`ifdef ONE_WIRE_CRC_EN
    logic [7:0] r_byte8;
    logic [7:0] r_crc;
    logic [7:0] r_shift;
    logic [2:0] r_bit;
    logic       r_crc_error;
    logic       w_crc_fb;
    logic [7:0] w_crc_next;

    // Dallas CRC-8, reflected form of x^8+x^5+x^4+1, one data bit per clock
    assign w_crc_fb   = r_crc[0] ^ r_shift[0];
    assign w_crc_next = {1'b0, r_crc[7:1]} ^ (w_crc_fb ? 8'h8C : 8'h00);
    assign w_fail_crc = (r_state == S_CHECK);
    assign crc_error  = r_crc_error;
`else
    assign w_fail_crc = 1'b0;
    assign crc_error  = 1'b0;
`endif

    assign temperature = r_temperature;
    assign temp_valid  = r_temp_valid;
    assign no_device   = r_no_device;

    always_comb begin
        w_next         = r_state;
        cmd_datain     = 8'h00;
        cmd_write      = 1'b0;
        cmd_read       = 1'b0;
        cmd_chipselect = 1'b0;
        cmd_bus_reset  = 1'b0;
        busy           = (r_state != S_IDLE);
        done           = (r_state == S_DONE) || (r_state == S_FAIL);
        case (r_state)
            S_IDLE:    if (r_pending && !cmd_busy) w_next = S_RST1;
            S_RST1:    begin cmd_bus_reset = 1'b1; w_next = S_RST1_W; end
            S_RST1_W:  if (!cmd_busy) w_next = cmd_no_device ? S_FAIL : S_SKIP1;
            S_SKIP1:   begin cmd_chipselect = 1'b1; cmd_write = 1'b1; cmd_datain = 8'hCC; w_next = S_SKIP1_W; end
            S_SKIP1_W: if (!cmd_busy) w_next = S_CONV;
            S_CONV:    begin cmd_chipselect = 1'b1; cmd_write = 1'b1; cmd_datain = 8'h44; w_next = S_CONV_W; end
            S_CONV_W:  if (!cmd_busy) w_next = S_DELAY;
            S_DELAY:   if (r_dly == DLY_LAST) w_next = S_RST2;
            S_RST2:    begin cmd_bus_reset = 1'b1; w_next = S_RST2_W; end
            S_RST2_W:  if (!cmd_busy) w_next = cmd_no_device ? S_FAIL : S_SKIP2;
            S_SKIP2:   begin cmd_chipselect = 1'b1; cmd_write = 1'b1; cmd_datain = 8'hCC; w_next = S_SKIP2_W; end
            S_SKIP2_W: if (!cmd_busy) w_next = S_RDCMD;
            S_RDCMD:   begin cmd_chipselect = 1'b1; cmd_write = 1'b1; cmd_datain = 8'hBE; w_next = S_RDCMD_W; end
            S_RDCMD_W: if (!cmd_busy) w_next = S_RDB;
            S_RDB:     begin cmd_chipselect = 1'b1; cmd_read = 1'b1; w_next = S_RDB_W; end
`ifdef ONE_WIRE_CRC_EN
            // every byte except the trailing CRC byte is folded into the running CRC
            S_RDB_W:   if (!cmd_busy) w_next = (r_index == LAST_IDX) ? S_TERM : S_CRC;
            S_CRC:     if (r_bit == 3'd7) w_next = S_RDB;
            S_CHECK:   w_next = (r_crc == r_byte8) ? S_DONE : S_FAIL;
`else
            S_RDB_W:   if (!cmd_busy) w_next = (r_index == LAST_IDX) ? S_TERM : S_RDB;
            S_CHECK:   w_next = S_DONE;
`endif
            S_TERM:    begin cmd_bus_reset = 1'b1; w_next = S_TERM_W; end
            S_TERM_W:  if (!cmd_busy) w_next = S_CHECK;
            S_DONE:    w_next = S_IDLE;
            S_FAIL:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge s_clock) begin
        if (!s_reset) begin
            r_state       <= S_IDLE;
            r_pending     <= 1'b0;
            r_dly         <= '0;
            r_index       <= 4'd0;
            r_byte0       <= 8'h00;
            r_byte1       <= 8'h00;
            r_temperature <= 16'h0000;
            r_temp_valid  <= 1'b0;
            r_no_device   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_next != S_IDLE)
                r_pending <= 1'b0;
            else if (start)
                r_pending <= 1'b1;

            if (r_state == S_DELAY)
                r_dly <= (r_dly == DLY_LAST) ? '0 : r_dly + 1'b1;

            if (r_state == S_IDLE) begin
                r_index <= 4'd0;
            end else if (w_rd_done) begin
                r_index <= r_index + 4'd1;
                if (r_index == 4'd0) r_byte0 <= cmd_rxdata;
                if (r_index == 4'd1) r_byte1 <= cmd_rxdata;
            end

            if (r_state == S_CHECK && w_next == S_DONE) begin
                r_temperature <= {r_byte1, r_byte0};
                r_temp_valid  <= 1'b1;
                r_no_device   <= 1'b0;
            end else if (w_next == S_FAIL) begin
                r_temp_valid  <= 1'b0;
                r_no_device   <= !w_fail_crc;
            end
        end
    end

`ifdef ONE_WIRE_CRC_EN
    always_ff @(posedge s_clock) begin
        if (!s_reset) begin
            r_byte8     <= 8'h00;
            r_crc       <= 8'h00;
            r_shift     <= 8'h00;
            r_bit       <= 3'd0;
            r_crc_error <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_crc <= 8'h00;
            end else if (r_state == S_CRC) begin
                r_crc   <= w_crc_next;
                r_shift <= {1'b0, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if (w_rd_done) begin
                r_shift <= cmd_rxdata;
                r_bit   <= 3'd0;
                if (r_index == LAST_IDX) r_byte8 <= cmd_rxdata;
            end
            if (r_state == S_CHECK && w_next == S_DONE)
                r_crc_error <= 1'b0;
            else if (w_next == S_FAIL)
                r_crc_error <= w_fail_crc;
        end
    end
`endif

endmodule

// File: tb/tb_one_wire_temp_sequencer.sv
// Bench: command-block/device mock, op-sequence and status model, randomized temperature cycles.
module tb_one_wire_temp_sequencer;
    localparam int SYSCLOCK = 100000;
    localparam int CONV_MS  = 2;
    localparam int DLY      = (SYSCLOCK / 1000) * CONV_MS;
`ifdef ONE_WIRE_CRC_EN
    localparam int NB = 9;
`else
    localparam int NB = 2;
`endif

    logic        s_clock = 1'b0;
    logic        s_reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, temp_valid, no_device, crc_error;
    logic [15:0] temperature;
    logic [7:0]  cmd_datain;
    logic        cmd_write, cmd_read, cmd_chipselect, cmd_bus_reset;
    logic        cmd_busy, cmd_no_device;
    logic [7:0]  cmd_rxdata = 8'h00;

    one_wire_temp_sequencer #(.SYSCLOCK(SYSCLOCK), .CONV_MS(CONV_MS), .DLY_WIDTH(25)) dut (
        .s_clock(s_clock), .s_reset(s_reset), .start(start),
        .busy(busy), .done(done), .temperature(temperature), .temp_valid(temp_valid),
        .no_device(no_device), .crc_error(crc_error),
        .cmd_datain(cmd_datain), .cmd_write(cmd_write), .cmd_read(cmd_read),
        .cmd_chipselect(cmd_chipselect), .cmd_bus_reset(cmd_bus_reset),
        .cmd_busy(cmd_busy), .cmd_no_device(cmd_no_device), .cmd_rxdata(cmd_rxdata)
    );

    always #5 s_clock = ~s_clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- command block + device mock ----------------
    logic       init_busy = 1'b0;
    logic       present = 1'b1;
    logic [7:0] image [9];
    int         mock_cnt = 0;
    int         rd_idx = 0;
    logic       mock_nodev = 1'b0;
    int         cyc = 0;

    always @(posedge s_clock) begin
        cyc <= cyc + 1;
        if (cmd_bus_reset) begin
            mock_cnt   <= $urandom_range(1, 6);
            mock_nodev <= !present;
            rd_idx     <= 0;
        end else if (cmd_chipselect && (cmd_write || cmd_read)) begin
            mock_cnt <= $urandom_range(1, 6);
            if (cmd_read) begin
                cmd_rxdata <= (rd_idx < 9) ? image[rd_idx] : 8'hFF;
                rd_idx     <= rd_idx + 1;
            end
        end else if (mock_cnt != 0) begin
            mock_cnt <= mock_cnt - 1;
        end
    end
    assign cmd_busy      = init_busy || (mock_cnt != 0);
    assign cmd_no_device = mock_nodev;

    function automatic logic [7:0] image_crc();
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ image[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 8'h8C;
            end
        return c;
    endfunction

    task automatic set_image(input logic [7:0] b0, input logic [7:0] b1);
        image[0] = b0; image[1] = b1; image[2] = 8'h4B; image[3] = 8'h46;
        image[4] = 8'h7F; image[5] = 8'hFF; image[6] = 8'h0C; image[7] = 8'h10;
        image[8] = image_crc();
    endtask

    // ---------------- reference model + compare process ----------------
    logic [9:0]  exp_q [$];
    logic [9:0]  got_op, exp_op;
    logic [1:0]  kind;
    logic        legal;
    logic [15:0] m_temp = 16'h0;
    logic        m_valid = 0, m_nodev = 0, m_crc = 0;
    int          done_cnt = 0;
    logic        prev_busy = 0, prev_done = 0;
    logic        delay_wait = 0, delay_arm = 0, init_arm = 0;
    int          conv_t = 0, t0 = 0, init_fall_cyc = 0;

    task automatic build_queue();
        exp_q.delete();
        exp_q.push_back({2'd1, 8'h00});
        if (present) begin
            exp_q.push_back({2'd2, 8'hCC});
            exp_q.push_back({2'd2, 8'h44});
            exp_q.push_back({2'd1, 8'h00});
            exp_q.push_back({2'd2, 8'hCC});
            exp_q.push_back({2'd2, 8'hBE});
            for (int i = 0; i < NB; i++) exp_q.push_back({2'd3, 8'h00});
            exp_q.push_back({2'd1, 8'h00});
        end
    endtask

    task automatic model_result();
        if (!present) begin
            m_nodev = 1; m_crc = 0; m_valid = 0;
`ifdef ONE_WIRE_CRC_EN
        end else if (image_crc() != image[8]) begin
            m_nodev = 0; m_crc = 1; m_valid = 0;
`endif
        end else begin
            m_temp = {image[1], image[0]}; m_valid = 1; m_nodev = 0; m_crc = 0;
        end
    endtask

    always @(negedge s_clock) begin
        if (!s_reset) begin
            exp_q.delete();
            m_temp = 16'h0; m_valid = 0; m_nodev = 0; m_crc = 0;
            prev_busy = 0; prev_done = 0; delay_wait = 0; delay_arm = 0;
        end else begin
            if (prev_done) begin
                check("busy_after_done", busy, 0);
                check("done_single_pulse", done, 0);
            end
            if (busy && !prev_busy) build_queue();
            if (delay_wait && cyc > conv_t && !cmd_busy) begin
                t0 = cyc; delay_wait = 0; delay_arm = 1;
            end
            if (cmd_bus_reset || cmd_chipselect || cmd_write || cmd_read) begin
                legal = (cmd_bus_reset && !cmd_chipselect && !cmd_write && !cmd_read) ||
                        (!cmd_bus_reset && cmd_chipselect && (cmd_write ^ cmd_read));
                check("strobe_legal", legal, 1);
                check("strobe_while_cmd_busy", cmd_busy, 0);
                kind   = cmd_bus_reset ? 2'd1 : (cmd_write ? 2'd2 : 2'd3);
                got_op = {kind, (kind == 2'd2) ? cmd_datain : 8'h00};
                check("op_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_op = exp_q.pop_front();
                    check("op_sequence", got_op, exp_op);
                end
                if (kind == 2'd2 && cmd_datain == 8'h44) begin
                    conv_t = cyc; delay_wait = 1;
                end
                if (kind == 2'd1 && delay_arm) begin
                    check("delay_length", cyc - t0, DLY + 1);
                    delay_arm = 0;
                end
                if (kind == 2'd1 && init_arm) begin
                    check("rst1_within_2_after_init", (cyc - init_fall_cyc >= 1) && (cyc - init_fall_cyc <= 2), 1);
                    init_arm = 0;
                end
            end
            if (done) begin
                check("done_with_busy", busy, 1);
                check("ops_left_at_done", exp_q.size(), 0);
                model_result();
                check("temperature", temperature, m_temp);
                check("temp_valid", temp_valid, m_valid);
                check("no_device", no_device, m_nodev);
                check("crc_error", crc_error, m_crc);
                done_cnt++;
            end
            prev_done = done;
            prev_busy = busy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        @(negedge s_clock); start = 1'b1;
        @(negedge s_clock); start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(posedge s_clock); n++;
        end
        check(name, done_cnt != d0, 1);
        repeat (2) @(posedge s_clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_temperature"}, temperature, 0);
        check({tag, "_flags"}, {temp_valid, no_device, crc_error}, 0);
        check({tag, "_cmd"}, {cmd_datain, cmd_write, cmd_read, cmd_chipselect, cmd_bus_reset}, 0);
    endtask

    initial begin
        int d0;
        int n;
        init_busy = 1'b1;
        set_image(8'h50, 8'h05);
        check("crc_model_pin", image_crc(), 8'h1C);
        repeat (3) @(negedge s_clock);
        check_reset_outputs("reset");

        // start during INIT busy, then the good-device cycle
        s_reset = 1'b1;
        pulse_start();
        repeat (30) @(negedge s_clock);
        check("idle_during_init", busy, 0);
        init_busy = 1'b0; init_fall_cyc = cyc; init_arm = 1'b1;
        wait_done("done_good_cycle");
        check("init_rst1_seen", init_arm, 0);
        check("good_temperature", temperature, 16'h0550);
        check("good_temp_valid", temp_valid, 1);

        // no device present
        present = 1'b0;
        pulse_start();
        wait_done("done_no_device");
        check("nodev_flag", no_device, 1);
        check("nodev_temp_valid", temp_valid, 0);
        check("nodev_temperature_kept", temperature, 16'h0550);
        present = 1'b1;

`ifdef ONE_WIRE_CRC_EN
        pulse_start();
        wait_done("done_restore");
        image[8] = 8'h00;
        pulse_start();
        wait_done("done_crc_bad");
        check("crcbad_flag", crc_error, 1);
        check("crcbad_temp_valid", temp_valid, 0);
        check("crcbad_temperature_kept", temperature, 16'h0550);
        set_image(8'h50, 8'h05);
`endif

        // two start pulses during a cycle -> exactly one extra cycle
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (!busy && n < 50) begin @(posedge s_clock); n++; end
        repeat (20) @(posedge s_clock);
        pulse_start();
        repeat (20) @(posedge s_clock);
        pulse_start();
        wait_done("done_double_1");
        wait_done("done_double_2");
        repeat (600) @(posedge s_clock);
        check("double_start_done_count", done_cnt - d0, 2);
        check("double_start_idle", busy, 0);

        // reset during DELAY, then a normal cycle
        pulse_start();
        n = 0;
        while (!delay_arm && n < 300) begin @(posedge s_clock); n++; end
        check("reached_delay", delay_arm, 1);
        repeat (20) @(posedge s_clock);
        @(negedge s_clock); s_reset = 1'b0;
        @(negedge s_clock);
        check_reset_outputs("midreset");
        @(negedge s_clock); s_reset = 1'b1;
        set_image(8'h91, 8'hFF);
        pulse_start();
        wait_done("done_after_reset");
        check("after_reset_temperature", temperature, 16'hFF91);

        // randomized cycles
        for (int it = 0; it < 16; it++) begin
            present = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < 8; i++) image[i] = 8'($urandom_range(0, 255));
            image[8] = image_crc();
`ifdef ONE_WIRE_CRC_EN
            if ($urandom_range(0, 3) == 0) image[8] = ~image[8];
`endif
            repeat ($urandom_range(0, 20)) @(posedge s_clock);
            pulse_start();
            wait_done("done_random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/one_wire_temp_sequencer.md
Name: one_wire_temp_sequencer

Overview:
- Transaction sequencer that owns a one_wire_commands instance and drives its Avalon slave port, bus_reset and status pins.
- On each start request it runs a full DS18B20-style temperature cycle: reset, Skip ROM, Convert T, conversion delay, reset, Skip ROM, Read Scratchpad, terminating reset.
- Presents the 16-bit temperature word and status flags to the host logic.

Parameters:
- SYSCLOCK, 24576000, s_clock frequency in Hz.
- CONV_MS, 750, conversion wait in milliseconds.
- DLY_WIDTH, 25, delay counter width; must hold (SYSCLOCK/1000)*CONV_MS.

Ports:
- s_clock  in  1  system clock; all timing derived from it
- s_reset  in  1  synchronous reset, active-low
- start  in  1  request a temperature cycle (level or pulse)
- busy  out  1  cycle in progress
- done  out  1  one-cycle pulse at end of every cycle, pass or fail
- temperature  out  16  last good scratchpad bytes 1:0 ({MSB,LSB})
- temp_valid  out  1  temperature holds a good reading
- no_device  out  1  last cycle saw no presence pulse
- crc_error  out  1  last cycle failed the CRC check
- cmd_datain  out  8  to command block s_datain
- cmd_write  out  1  to s_write
- cmd_read  out  1  to s_read
- cmd_chipselect  out  1  to s_chipselect
- cmd_bus_reset  out  1  to bus_reset
- cmd_busy  in  1  from command block busy
- cmd_no_device  in  1  from command block no_device
- cmd_rxdata  in  8  from command block rxdata

Behaviour:
- Reset (s_reset low at a clock edge): all outputs 0, FSM to IDLE, pending start cleared, delay and byte counters 0.
- start seen high in any state sets a pending flag. IDLE leaves only when pending=1 and cmd_busy=0. This covers the command block's 480 us INIT busy. Pending clears on leaving IDLE.
- Command issue rule: an ISSUE state drives exactly one cycle with cmd_chipselect=1 plus cmd_write or cmd_read (cmd_datain valid), or cmd_bus_reset=1. It then enters the matching WAIT state, which exits on the first cycle with cmd_busy=0. Strobes are never asserted in WAIT states.
- Cycle states and transitions:
  - IDLE
  - RST1 / RST1_W: if cmd_no_device=1, go to FAIL.
  - SKIP1 / SKIP1_W: write 0xCC.
  - CONV / CONV_W: write 0x44.
  - DELAY: count to (SYSCLOCK/1000)*CONV_MS-1 (18431999 at defaults), then advance.
  - RST2 / RST2_W: presence check as in RST1.
  - SKIP2 / SKIP2_W: write 0xCC.
  - RDCMD / RDCMD_W: write 0xBE.
  - RDB / RDB_W: read one byte. On exit, store cmd_rxdata into byte slot [index]. index+1; loop until NBYTES read.
  - TERM / TERM_W: bus reset to abort the scratchpad stream; presence is ignored here.
  - CHECK
  - DONE or FAIL, then IDLE.
- CHECK: on success, temperature <= {byte1,byte0}, temp_valid=1, crc_error=0, no_device=0.
- FAIL: no_device=1 (presence failure) or crc_error=1 (CRC failure). temp_valid=0; temperature keeps its old value.
- done pulses for one cycle in DONE/FAIL. busy=1 from the cycle after IDLE exit through DONE/FAIL inclusive.
- A start asserted during a cycle is latched as pending and runs immediately after the current cycle. At most one is queued.
- Reset mid-cycle: the FSM drops to IDLE in one cycle and strobes deassert. The command block finishes its own operation; the next cycle waits on cmd_busy.
- Without CRC (see below): NBYTES=2.

Optional Feature:
- Macro ONE_WIRE_CRC_EN.
- Defined: NBYTES=9. A serial Dallas CRC-8 (x^8+x^5+x^4+1, init 0x00, LSB-first, 8 cycles per byte) runs over bytes 0..7 in a CRC state after each store. CHECK compares the result with byte 8; a mismatch goes to FAIL with crc_error=1.
- Not defined: NBYTES=2, no CRC logic, crc_error tied 0.

Test Plan:
- Device model present, scratchpad 0x50,0x05 (CRC-valid 9-byte image) -> bus writes CC,44,CC,BE in order. DELAY lasts exactly 18432000 cycles (shortened with CONV_MS=1 in sim: 24576 cycles). temperature=0x0550, temp_valid=1, done one pulse.
- No device (bus held high) -> after RST1, no SKIP write occurs. no_device=1, temp_valid=0, done pulses, busy low next cycle.
- ONE_WIRE_CRC_EN, byte 8 corrupted to 0x00 -> crc_error=1, temp_valid=0, temperature unchanged from prior good 0x0550.
- start asserted during the command block's INIT busy -> no strobe until cmd_busy falls, then RST1 issued within 2 cycles.
- start pulsed twice during a cycle -> exactly one additional cycle follows, two done pulses total.
- s_reset low during DELAY -> next cycle: all outputs 0, FSM IDLE. A new start completes normally after cmd_busy=0.
